// File: rtl/data_sram_ctrl.sv
// Two-slot load/store controller for the data SRAM bus. Slot 0 is always serviced
// before slot 1 on a split address/data-phase bus; load data is lane-selected and extended.
module data_sram_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             req_valid,
  input  logic [1:0]             req_we,
  input  logic [1:0][1:0]        req_size,
  input  logic [1:0]             req_signed,
  input  logic [1:0][ADDR_W-1:0] req_addr,
  input  logic [1:0][DATA_W-1:0] req_wdata,
  input  logic                   flush,
  output logic                   bus_req,
  output logic                   bus_we,
  output logic [ADDR_W-1:0]      bus_addr,
  output logic [3:0]             bus_wstrb,
  output logic [DATA_W-1:0]      bus_wdata,
  input  logic                   bus_addr_ok,
  input  logic                   bus_data_ok,
  input  logic [DATA_W-1:0]      bus_rdata,
  output logic                   stall_from_memory,
  output logic [1:0][DATA_W-1:0] memory_result,
  output logic [1:0]             misalign,
  output logic [1:0]             dbg_state_o, // 0=IDLE 1=ADDR 2=DATA 3=DONE
  output logic                   dbg_ptr_o
);

  // Handshakes: the address phase is accepted on any cycle with bus_req && bus_addr_ok;
  // the data phase completes on the first DATA cycle with bus_data_ok. Upstream holds the
  // request while stall_from_memory is 1 and consumes the results in the DONE cycle.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ADDR = 2'd1, S_DATA = 2'd2, S_DONE = 2'd3} state_e;

  state_e                 state_q, state_d;
  logic                   ptr_q, ptr_d;
  logic                   flushed_q, flushed_d;
  logic [1:0]             go_q, mis_q;
  logic [1:0][DATA_W-1:0] result_q;
  logic [1:0]             we_q, signed_q;
  logic [1:0][1:0]        size_q;
  logic [1:0][ADDR_W-1:0] addr_q;
  logic [1:0][DATA_W-1:0] wdata_q;
  logic [1:0]             mis_in, go_in;
  logic                   accept, capture;
  logic [1:0]             cur_off, cur_size;

  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'd0:    is_aligned = 1'b1;
      2'd1:    is_aligned = ~off[0];
      default: is_aligned = (off == 2'b00);
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] raw, input logic [1:0] size,
                                           input logic sgn, input logic [1:0] off);
    logic [31:0] sh;
    sh = raw >> {off, 3'b000};
    case (size)
      2'd0:    load_ext = {{24{sgn & sh[7]}}, sh[7:0]};
      2'd1:    load_ext = {{16{sgn & sh[15]}}, sh[15:0]};
      default: load_ext = raw;
    endcase
  endfunction

  always_comb begin
    mis_in = '0;
    for (int s = 0; s < 2; s++) begin
      mis_in[s] = req_valid[s] & ~is_aligned(req_size[s], req_addr[s][1:0]);
    end
    go_in = req_valid & ~mis_in;
  end

  always_comb begin
    state_d           = state_q;
    ptr_d             = ptr_q;
    flushed_d         = flushed_q;
    accept            = 1'b0;
    capture           = 1'b0;
    stall_from_memory = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|req_valid && !flush) begin
          accept            = 1'b1;
          stall_from_memory = 1'b1;
          if (go_in[0]) begin
            ptr_d   = 1'b0;
            state_d = S_ADDR;
          end else if (go_in[1]) begin
            ptr_d   = 1'b1;
            state_d = S_ADDR;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_ADDR: begin
        stall_from_memory = 1'b1;
        // An accepted address phase must finish its data phase even if flushed now.
        if (bus_addr_ok) begin
          state_d   = S_DATA;
          flushed_d = flush;
        end else if (flush) begin
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        stall_from_memory = 1'b1;
        if (flush) flushed_d = 1'b1;
        if (bus_data_ok) begin
          flushed_d = 1'b0;
          if (flush || flushed_q) begin
            state_d = S_IDLE;
          end else begin
            capture = 1'b1;
            if (!ptr_q && go_q[1]) begin
              ptr_d   = 1'b1;
              state_d = S_ADDR;
            end else begin
              state_d = S_DONE;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cur_off  = addr_q[ptr_q][1:0];
  assign cur_size = size_q[ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= 1'b0;
      flushed_q <= 1'b0;
      go_q      <= '0;
      mis_q     <= '0;
      result_q  <= '0;
      we_q      <= '0;
      signed_q  <= '0;
      size_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      flushed_q <= flushed_d;
      if (accept) begin
        we_q     <= req_we;
        signed_q <= req_signed;
        size_q   <= req_size;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        go_q     <= go_in;
        mis_q    <= mis_in;
        result_q <= '0;
      end
      if (capture) begin
        result_q[ptr_q] <= we_q[ptr_q] ? '0
                         : load_ext(bus_rdata, cur_size, signed_q[ptr_q], cur_off);
      end
    end
  end

  assign bus_req  = (state_q == S_ADDR);
  assign bus_we   = bus_req & we_q[ptr_q];
  assign bus_addr = {addr_q[ptr_q][ADDR_W-1:2], 2'b00};

  always_comb begin
    bus_wstrb = 4'b0000;
    if (bus_we) begin
      case (cur_size)
        2'd0:    bus_wstrb = 4'b0001 << cur_off;
        2'd1:    bus_wstrb = 4'b0011 << cur_off;
        default: bus_wstrb = 4'b1111;
      endcase
    end
    case (cur_size)
      2'd0:    bus_wdata = {4{wdata_q[ptr_q][7:0]}};
      2'd1:    bus_wdata = {2{wdata_q[ptr_q][15:0]}};
      default: bus_wdata = wdata_q[ptr_q];
    endcase
  end

  assign memory_result = result_q;
  assign misalign      = mis_q;
  assign dbg_state_o   = state_q;
  assign dbg_ptr_o     = ptr_q;

endmodule

// File: tb/tb_data_sram_ctrl.sv
// Bench for data_sram_ctrl: a randomised bus slave with a byte memory, plus a byte-level
// reference memory from which expected bus commands and load results are derived.
module tb_data_sram_ctrl;
  localparam int CW = 69; // {we, addr[31:0], strb[3:0], wdata[31:0]}

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] req_valid = '0, req_we = '0, req_signed = '0;
  logic [1:0][1:0] req_size = '0;
  logic [1:0][31:0] req_addr = '0, req_wdata = '0;
  logic flush = 1'b0;
  logic bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0] bus_wstrb;
  logic bus_addr_ok, bus_data_ok;
  logic stall_from_memory;
  logic [1:0][31:0] memory_result;
  logic [1:0] misalign, dbg_state;
  logic dbg_ptr;

  logic auto_bus = 1'b1;
  logic man_addr_ok = 1'b0, man_data_ok = 1'b0;
  logic [31:0] man_rdata = '0;
  logic rsp_addr_ok = 1'b0, rsp_data_ok = 1'b0;
  logic [31:0] rsp_rdata = '0;
  int rsp_phase, rsp_cnt, rsp_wi;
  logic rsp_we;
  logic [3:0] rsp_strb;
  logic [31:0] rsp_wdata;

  logic [7:0] bus_mem [0:1023];
  logic [7:0] ref_mem [0:1023];
  logic [CW-1:0] exp_q[$];
  logic [CW-1:0] got_log[$];
  int n_cmp = 0, n_fail = 0;
  int last_stall, last_base;
  logic [1:0][31:0] last_res;
  logic [1:0] last_mis;

  assign bus_addr_ok = auto_bus ? rsp_addr_ok : man_addr_ok;
  assign bus_data_ok = auto_bus ? rsp_data_ok : man_data_ok;
  assign bus_rdata   = auto_bus ? rsp_rdata : man_rdata;

  always #5 clk = ~clk;

  data_sram_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata), .flush(flush),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wstrb(bus_wstrb),
    .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
    .bus_rdata(bus_rdata), .stall_from_memory(stall_from_memory),
    .memory_result(memory_result), .misalign(misalign), .dbg_state_o(dbg_state),
    .dbg_ptr_o(dbg_ptr)
  );

  // Issue one request pair, wait for DONE and compare against the byte-level model.
  task automatic run_op(input logic [1:0] v, input logic [1:0] we, input logic [1:0][1:0] sz,
                        input logic [1:0] sg, input logic [1:0][31:0] ad,
                        input logic [1:0][31:0] wd, input string tag);
    logic [1:0] exp_mis;
    logic [1:0][31:0] exp_res;
    logic [31:0] val;
    logic [3:0] strb;
    int n, a, base, stall_cnt;
    exp_q.delete();
    exp_mis = '0;
    exp_res = '0;
    for (int s = 0; s < 2; s++) begin
      if (v[s]) begin
        n = 1 << sz[s];
        a = int'(ad[s][9:0]);
        if (a % n != 0) begin
          exp_mis[s] = 1'b1;
        end else if (we[s]) begin
          strb = '0;
          val  = '0;
          for (int i = 0; i < n; i++) begin
            strb[a % 4 + i] = 1'b1;
            ref_mem[a + i] = wd[s][8*i +: 8];
          end
          for (int i = 0; i < 4; i++) val[8*i +: 8] = wd[s][8*(i % n) +: 8];
          exp_q.push_back({1'b1, 32'(a - a % 4), strb, val});
        end else begin
          val = '0;
          for (int i = 0; i < n; i++) val[8*i +: 8] = ref_mem[a + i];
          if (sg[s] && val[8*n-1]) for (int i = n; i < 4; i++) val[8*i +: 8] = 8'hFF;
          exp_res[s] = val;
          exp_q.push_back({1'b0, 32'(a - a % 4), 4'b0000, 32'h0});
        end
      end
    end
    base = got_log.size();
    req_valid = v; req_we = we; req_size = sz; req_signed = sg; req_addr = ad; req_wdata = wd;
    #1;
    stall_cnt = 0;
    while (stall_from_memory === 1'b1 && stall_cnt < 100) begin
      stall_cnt++;
      @(negedge clk);
      #1;
    end
    n_cmp++;
    if (stall_from_memory !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done_timeout: stall=%b after %0d cycles, required 0", tag, stall_from_memory, stall_cnt);
    end
    n_cmp++;
    if (misalign !== exp_mis) begin
      n_fail++;
      $display("FAIL %s misalign: got %b, expected %b", tag, misalign, exp_mis);
    end
    for (int s = 0; s < 2; s++) begin
      if (v[s] && !(we[s] && !exp_mis[s])) begin
        n_cmp++;
        if (memory_result[s] !== exp_res[s]) begin
          n_fail++;
          $display("FAIL %s result[%0d]: got %h, expected %h", tag, s, memory_result[s], exp_res[s]);
        end
      end
    end
    n_cmp++;
    if (got_log.size() - base != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s bus_count: got %0d, expected %0d", tag, got_log.size() - base, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++;
        if (got_log[base + i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL %s bus_cmd[%0d]: got %h, expected %h", tag, i, got_log[base + i], exp_q[i]);
        end
      end
    end
    last_stall = stall_cnt; last_res = memory_result; last_mis = misalign; last_base = base;
    req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL reset bus_req: got %b, expected 0", bus_req); end
    n_cmp++; if (bus_wstrb !== 4'h0) begin n_fail++; $display("FAIL reset wstrb: got %b, expected 0000", bus_wstrb); end
    n_cmp++; if (stall_from_memory !== 1'b0) begin n_fail++; $display("FAIL reset stall: got %b, expected 0", stall_from_memory); end
    n_cmp++; if (memory_result !== 64'h0) begin n_fail++; $display("FAIL reset result: got %h, expected 0", memory_result); end
    n_cmp++; if (misalign !== 2'b00) begin n_fail++; $display("FAIL reset misalign: got %b, expected 00", misalign); end
    n_cmp++; if (dbg_state !== 2'd0 || dbg_ptr !== 1'b0) begin n_fail++; $display("FAIL reset state/ptr: got %0d/%b, expected 0/0", dbg_state, dbg_ptr); end
  endtask

  task automatic test_lw_timing();
    int sc;
    auto_bus = 1'b0;
    sc = 0;
    req_valid = 2'b01; req_we = '0; req_signed = '0; req_size[0] = 2'd2; req_addr[0] = 32'h100;
    #1; if (stall_from_memory) sc++;
    @(negedge clk); #1; if (stall_from_memory) sc++;
    n_cmp++;
    if (bus_req !== 1'b1 || bus_addr !== 32'h100 || bus_wstrb !== 4'h0 || bus_we !== 1'b0) begin
      n_fail++;
      $display("FAIL lw_addr_phase: got req=%b addr=%h strb=%b we=%b, expected 1 00000100 0000 0", bus_req, bus_addr, bus_wstrb, bus_we);
    end
    @(negedge clk); man_addr_ok = 1'b1; #1; if (stall_from_memory) sc++;
    @(negedge clk); man_addr_ok = 1'b0; #1; if (stall_from_memory) sc++;
    n_cmp++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL lw_req_drop: got %b, expected 0", bus_req); end
    @(negedge clk); #1; if (stall_from_memory) sc++;
    @(negedge clk); man_data_ok = 1'b1; man_rdata = 32'hDEADBEEF; #1; if (stall_from_memory) sc++;
    @(negedge clk); man_data_ok = 1'b0; #1;
    n_cmp++; if (stall_from_memory !== 1'b0) begin n_fail++; $display("FAIL lw_done_stall: got %b, expected 0", stall_from_memory); end
    n_cmp++; if (memory_result[0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_result: got %h, expected deadbeef", memory_result[0]); end
    n_cmp++; if (sc != 6) begin n_fail++; $display("FAIL lw_stall_cycles: got %0d, expected 6", sc); end
    req_valid = '0;
    @(negedge clk);
    auto_bus = 1'b1;
  endtask

  task automatic test_store_to_load();
    logic [1:0][1:0] sz;
    logic [1:0][31:0] ad, wd;
    for (int i = 16'h200; i < 16'h204; i++) begin bus_mem[i] = 8'h00; ref_mem[i] = 8'h00; end
    sz[0] = 2'd0; sz[1] = 2'd0; ad[0] = 32'h203; ad[1] = 32'h203; wd[0] = 32'hA5; wd[1] = 32'h0;
    run_op(2'b11, 2'b01, sz, 2'b10, ad, wd, "sb_lb");
    n_cmp++;
    if (got_log[last_base] !== {1'b1, 32'h200, 4'b1000, 32'hA5A5A5A5}) begin
      n_fail++; $display("FAIL sb_cmd: got %h, expected 1 00000200 8 a5a5a5a5", got_log[last_base]);
    end
    n_cmp++; if (last_res[1] !== 32'hFFFFFFA5) begin n_fail++; $display("FAIL lb_result: got %h, expected ffffffa5", last_res[1]); end
  endtask

  task automatic test_misalign();
    logic [1:0][1:0] sz;
    logic [1:0][31:0] ad, wd;
    sz[0] = 2'd1; sz[1] = 2'd2; ad[0] = 32'h101; ad[1] = 32'h104; wd = '0;
    run_op(2'b11, 2'b00, sz, 2'b00, ad, wd, "lh_mis_lw");
    n_cmp++; if (last_mis !== 2'b01) begin n_fail++; $display("FAIL mis_flags: got %b, expected 01", last_mis); end
    n_cmp++;
    if (got_log.size() - last_base != 1 || got_log[last_base][67:36] !== 32'h104) begin
      n_fail++; $display("FAIL mis_bus: got %0d accesses first addr %h, expected 1 at 00000104", got_log.size() - last_base, got_log[last_base][67:36]);
    end
    n_cmp++; if (last_res[0] !== 32'h0) begin n_fail++; $display("FAIL mis_result0: got %h, expected 0", last_res[0]); end
    sz[0] = 2'd2; sz[1] = 2'd1; ad[0] = 32'h102; ad[1] = 32'h105;
    run_op(2'b11, 2'b10, sz, 2'b00, ad, wd, "all_mis");
    n_cmp++; if (last_stall != 1) begin n_fail++; $display("FAIL all_mis_stall: got %0d cycles, expected 1", last_stall); end
  endtask

  task automatic test_flush_data();
    logic [1:0][1:0] sz;
    logic [1:0][31:0] ad, wd;
    auto_bus = 1'b0;
    req_valid = 2'b01; req_we = '0; req_signed = '0; req_size[0] = 2'd2; req_addr[0] = 32'h40;
    @(negedge clk); man_addr_ok = 1'b1;
    @(negedge clk); man_addr_ok = 1'b0; flush = 1'b1; req_valid = '0;
    @(negedge clk); flush = 1'b0; #1;
    n_cmp++; if (stall_from_memory !== 1'b1 || bus_req !== 1'b0) begin n_fail++; $display("FAIL flush_wait: got stall=%b req=%b, expected 1 0", stall_from_memory, bus_req); end
    @(negedge clk); man_data_ok = 1'b1; man_rdata = 32'hCAFEF00D;
    @(negedge clk); man_data_ok = 1'b0; #1;
    n_cmp++; if (stall_from_memory !== 1'b0 || dbg_state !== 2'd0) begin n_fail++; $display("FAIL flush_end: got stall=%b state=%0d, expected 0 0", stall_from_memory, dbg_state); end
    n_cmp++; if (memory_result[0] === 32'hCAFEF00D) begin n_fail++; $display("FAIL flush_discard: got %h, expected not cafef00d", memory_result[0]); end
    @(negedge clk);
    auto_bus = 1'b1;
    sz = '0; sz[0] = 2'd2; ad[0] = 32'h40; ad[1] = 32'h0; wd = '0;
    run_op(2'b01, 2'b00, sz, 2'b00, ad, wd, "after_flush");
  endtask

  task automatic test_flush_addr();
    auto_bus = 1'b0;
    req_valid = 2'b01; req_we = '0; req_size[0] = 2'd2; req_addr[0] = 32'h80;
    @(negedge clk); #1;
    n_cmp++; if (bus_req !== 1'b1) begin n_fail++; $display("FAIL fa_req: got %b, expected 1", bus_req); end
    flush = 1'b1; req_valid = '0;
    @(negedge clk); flush = 1'b0; #1;
    n_cmp++; if (dbg_state !== 2'd0 || bus_req !== 1'b0 || stall_from_memory !== 1'b0) begin n_fail++; $display("FAIL fa_idle: got state=%0d req=%b stall=%b, expected 0 0 0", dbg_state, bus_req, stall_from_memory); end
    man_addr_ok = 1'b1; man_data_ok = 1'b1;
    @(negedge clk); man_addr_ok = 1'b0; man_data_ok = 1'b0; #1;
    n_cmp++; if (dbg_state !== 2'd0 || bus_req !== 1'b0) begin n_fail++; $display("FAIL late_rsp: got state=%0d req=%b, expected 0 0", dbg_state, bus_req); end
    auto_bus = 1'b1;
  endtask

  task automatic test_same_cycle_ok();
    auto_bus = 1'b0;
    req_valid = 2'b01; req_we = '0; req_signed = '0; req_size[0] = 2'd2; req_addr[0] = 32'h108;
    @(negedge clk); man_addr_ok = 1'b1; man_data_ok = 1'b1; man_rdata = 32'h11111111;
    @(negedge clk); man_addr_ok = 1'b0; man_data_ok = 1'b0; #1;
    n_cmp++; if (dbg_state !== 2'd2 || stall_from_memory !== 1'b1) begin n_fail++; $display("FAIL both_ok_state: got %0d stall=%b, expected 2 1", dbg_state, stall_from_memory); end
    @(negedge clk); man_data_ok = 1'b1; man_rdata = 32'h12345678;
    @(negedge clk); man_data_ok = 1'b0; #1;
    n_cmp++; if (memory_result[0] !== 32'h12345678) begin n_fail++; $display("FAIL both_ok_result: got %h, expected 12345678", memory_result[0]); end
    req_valid = '0;
    @(negedge clk);
    auto_bus = 1'b1;
  endtask

  task automatic test_reset_in_addr();
    auto_bus = 1'b0;
    req_valid = 2'b11; req_we = 2'b01; req_size[0] = 2'd2; req_size[1] = 2'd1;
    req_addr[0] = 32'h10; req_addr[1] = 32'h21; req_wdata[0] = 32'h01020304;
    @(negedge clk); #1;
    n_cmp++; if (bus_req !== 1'b1 || bus_wstrb !== 4'hF) begin n_fail++; $display("FAIL ra_addr: got req=%b strb=%b, expected 1 1111", bus_req, bus_wstrb); end
    rst = 1'b1; req_valid = '0;
    @(negedge clk); rst = 1'b0; #1;
    n_cmp++; if (bus_req !== 1'b0 || stall_from_memory !== 1'b0 || dbg_state !== 2'd0) begin n_fail++; $display("FAIL ra_idle: got req=%b stall=%b state=%0d, expected 0 0 0", bus_req, stall_from_memory, dbg_state); end
    n_cmp++; if (misalign !== 2'b00 || memory_result !== 64'h0 || bus_wstrb !== 4'h0) begin n_fail++; $display("FAIL ra_clear: got mis=%b res=%h strb=%b, expected 00 0 0000", misalign, memory_result, bus_wstrb); end
    auto_bus = 1'b1;
  endtask

  task automatic test_half_ext();
    logic [1:0][1:0] sz;
    logic [1:0][31:0] ad, wd;
    bus_mem[32'h102] = 8'h01; ref_mem[32'h102] = 8'h01;
    bus_mem[32'h103] = 8'h80; ref_mem[32'h103] = 8'h80;
    sz = '0; sz[0] = 2'd1; ad = '0; ad[0] = 32'h102; wd = '0;
    run_op(2'b01, 2'b00, sz, 2'b00, ad, wd, "lhu");
    n_cmp++; if (last_res[0] !== 32'h00008001) begin n_fail++; $display("FAIL lhu_result: got %h, expected 00008001", last_res[0]); end
    run_op(2'b01, 2'b00, sz, 2'b01, ad, wd, "lh");
    n_cmp++; if (last_res[0] !== 32'hFFFF8001) begin n_fail++; $display("FAIL lh_result: got %h, expected ffff8001", last_res[0]); end
  endtask

  task automatic test_random();
    logic [1:0][1:0] sz;
    logic [1:0][31:0] ad, wd;
    logic [1:0] v, we, sg;
    for (int k = 0; k < 40; k++) begin
      v  = 2'($urandom_range(1, 3));
      we = 2'($urandom_range(0, 3));
      sg = 2'($urandom_range(0, 3));
      for (int s = 0; s < 2; s++) begin
        sz[s] = 2'($urandom_range(0, 2));
        ad[s] = 32'($urandom_range(0, 127));
        wd[s] = $urandom;
      end
      run_op(v, we, sz, sg, ad, wd, "random");
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      bus_mem[i] = 8'($urandom);
      ref_mem[i] = bus_mem[i];
    end
    rsp_phase = 0; rsp_cnt = 0; rsp_wi = 0; rsp_we = 1'b0; rsp_strb = '0; rsp_wdata = '0;
    fork
      begin : responder
        forever begin
          @(negedge clk);
          rsp_addr_ok = 1'b0;
          rsp_data_ok = 1'b0;
          if (rst || !auto_bus) begin
            rsp_phase = 0;
          end else begin
            if (rsp_phase == 0 && bus_req) begin
              rsp_phase = 1;
              rsp_cnt = int'($urandom_range(0, 2));
            end
            if (rsp_phase == 1) begin
              if (!bus_req) begin
                rsp_phase = 0;
              end else if (rsp_cnt == 0) begin
                rsp_addr_ok = 1'b1;
                rsp_we = bus_we; rsp_strb = bus_wstrb; rsp_wdata = bus_wdata;
                rsp_wi = int'(bus_addr[9:0]);
                got_log.push_back({bus_we, bus_addr, bus_wstrb, bus_we ? bus_wdata : 32'h0});
                rsp_phase = 2;
                rsp_cnt = int'($urandom_range(0, 3));
              end else begin
                rsp_cnt--;
              end
            end else if (rsp_phase == 2) begin
              if (rsp_cnt == 0) begin
                rsp_data_ok = 1'b1;
                if (rsp_we) begin
                  rsp_rdata = $urandom;
                  for (int i = 0; i < 4; i++) if (rsp_strb[i]) bus_mem[rsp_wi + i] = rsp_wdata[8*i +: 8];
                end else begin
                  rsp_rdata = {bus_mem[rsp_wi + 3], bus_mem[rsp_wi + 2], bus_mem[rsp_wi + 1], bus_mem[rsp_wi]};
                end
                rsp_phase = 0;
              end else begin
                rsp_cnt--;
              end
            end
          end
        end
      end
      begin : main
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        @(negedge clk);
        test_lw_timing();
        test_store_to_load();
        test_misalign();
        test_flush_data();
        test_flush_addr();
        test_same_cycle_ok();
        test_reset_in_addr();
        test_half_ext();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
      end
    join
  end

endmodule
